// File: rtl/tile_move_writer.sv
// Moves a sprite on a row-organised tile map: clears the source tile, writes the
// destination tile and reports what the sprite landed on, using read-modify-write rows.
module tile_move_writer #(
    parameter int ROW_W  = 160,
    parameter int TILE_W = 4,
    parameter int N_COLS = 40,
    parameter int N_ROWS = 30
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        src_x,
    input  logic [4:0]        src_y,
    input  logic [5:0]        dst_x,
    input  logic [4:0]        dst_y,
    input  logic [TILE_W-1:0] tile_code,
    input  logic [TILE_W-1:0] src_fill,
    output logic [4:0]        ram_addr,
    input  logic [ROW_W-1:0]  ram_rddata,
    output logic [ROW_W-1:0]  ram_wrdata,
    output logic              ram_wren,
    output logic              done,
    output logic              err,
    output logic [TILE_W-1:0] collision
);

    typedef enum logic [3:0] {
        IDLE, CHECK, RD_SRC, WAIT_SRC, WR_SRC, RD_DST, WAIT_DST, WR_DST, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        src_x_q, src_x_d, dst_x_q, dst_x_d;
    logic [4:0]        src_y_q, src_y_d, dst_y_q, dst_y_d;
    logic [TILE_W-1:0] tile_code_q, tile_code_d, src_fill_q, src_fill_d;
    logic [TILE_W-1:0] collision_q, collision_d;
    logic [ROW_W-1:0]  row_buf_q, row_buf_d;
    logic              err_q, err_d;

    logic              out_of_range;
    logic              same_row;
    logic [ROW_W-1:0]  src_row;

    // Tile x lives at the MSB end of the row for x = 0.
    function automatic logic [TILE_W-1:0] get_tile(input logic [ROW_W-1:0] row,
                                                   input logic [5:0] x);
        logic [TILE_W-1:0] t;
        t = '0;
        for (int i = 0; i < N_COLS; i++) begin
            if (int'(x) == i) t = row[ROW_W-1-TILE_W*i -: TILE_W];
        end
        return t;
    endfunction

    function automatic logic [ROW_W-1:0] put_tile(input logic [ROW_W-1:0]  row,
                                                  input logic [5:0]        x,
                                                  input logic [TILE_W-1:0] code);
        logic [ROW_W-1:0] r;
        r = row;
        for (int i = 0; i < N_COLS; i++) begin
            if (int'(x) == i) r[ROW_W-1-TILE_W*i -: TILE_W] = code;
        end
        return r;
    endfunction

    assign out_of_range = (int'(src_x_q) >= N_COLS) || (int'(dst_x_q) >= N_COLS) ||
                          (int'(src_y_q) >= N_ROWS) || (int'(dst_y_q) >= N_ROWS);
    assign same_row     = (src_y_q == dst_y_q);
    assign src_row      = put_tile(row_buf_q, src_x_q, src_fill_q);
    assign collision    = collision_q;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        src_x_d     = src_x_q;
        src_y_d     = src_y_q;
        dst_x_d     = dst_x_q;
        dst_y_d     = dst_y_q;
        tile_code_d = tile_code_q;
        src_fill_d  = src_fill_q;
        collision_d = collision_q;
        row_buf_d   = row_buf_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        ram_addr    = '0;
        ram_wrdata  = '0;
        ram_wren    = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    src_x_d     = src_x;
                    src_y_d     = src_y;
                    dst_x_d     = dst_x;
                    dst_y_d     = dst_y;
                    tile_code_d = tile_code;
                    src_fill_d  = src_fill;
                    err_d       = 1'b0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (out_of_range) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RD_SRC;
                end
            end
            RD_SRC: begin
                ram_addr = src_y_q;
                state_d  = WAIT_SRC;
            end
            WAIT_SRC: begin
                ram_addr  = src_y_q;
                row_buf_d = ram_rddata;
                state_d   = WR_SRC;
            end
            WR_SRC: begin
                ram_addr = src_y_q;
                ram_wren = 1'b1;
                if (same_row) begin
                    // Destination applied last so tile_code wins when src == dst.
                    ram_wrdata  = put_tile(src_row, dst_x_q, tile_code_q);
                    collision_d = get_tile(row_buf_q, dst_x_q);
                    state_d     = DONE;
                end else begin
                    ram_wrdata = src_row;
                    state_d    = RD_DST;
                end
            end
            RD_DST: begin
                ram_addr = dst_y_q;
                state_d  = WAIT_DST;
            end
            WAIT_DST: begin
                ram_addr    = dst_y_q;
                row_buf_d   = ram_rddata;
                collision_d = get_tile(ram_rddata, dst_x_q);
                state_d     = WR_DST;
            end
            WR_DST: begin
                ram_addr   = dst_y_q;
                ram_wren   = 1'b1;
                ram_wrdata = put_tile(row_buf_q, dst_x_q, tile_code_q);
                state_d    = DONE;
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= IDLE;
            src_x_q     <= '0;
            src_y_q     <= '0;
            dst_x_q     <= '0;
            dst_y_q     <= '0;
            tile_code_q <= '0;
            src_fill_q  <= '0;
            collision_q <= '0;
            // NOTE: the row buffer is a plain register, so clearing it on reset is cheap.
            row_buf_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            dst_x_q     <= dst_x_d;
            dst_y_q     <= dst_y_d;
            tile_code_q <= tile_code_d;
            src_fill_q  <= src_fill_d;
            collision_q <= collision_d;
            row_buf_q   <= row_buf_d;
            err_q       <= err_d;
        end
    end

endmodule
